sram22_param_model: RTL and testbench
=====================================

SRAM22_PARAM_MODEL -- requirements
Module: sram22_param_model

Interface
REQ-001 Parameter DATA_WIDTH, default 8: data word width in bits, minimum 1.
REQ-002 Parameter ADDR_WIDTH, default 12: address width in bits.
REQ-003 Parameter RAM_DEPTH, default 1<<ADDR_WIDTH: number of implemented words; legal range 1..2^ADDR_WIDTH.
REQ-004 Parameter MASK_GRAN, default 8: bits per write-mask granule; DATA_WIDTH SHALL be a multiple of MASK_GRAN.
REQ-005 Parameter WMASK_WIDTH, derived as DATA_WIDTH/MASK_GRAN: write-mask width; never overridden.
REQ-006 Parameter READ_LATENCY, default 1: clock edges from read acceptance to data on dout; legal range 1..4.
REQ-007 Any illegal parameter combination SHALL stop elaboration with an error.
REQ-008 clk  input  1  clock; all state updates on the rising edge.
REQ-009 rst_n  input  1  asynchronous, active-low reset.
REQ-010 en  input  1  access enable; no access when low.
REQ-011 we  input  1  1 = write, 0 = read (qualified by en).
REQ-012 wmask  input  WMASK_WIDTH  per-granule write enable.
REQ-013 addr  input  ADDR_WIDTH  word address.
REQ-014 din  input  DATA_WIDTH  write data.
REQ-015 dout  output  DATA_WIDTH  registered read data.
REQ-016 dout_valid  output  1  one-cycle strobe marking new read data on dout.
REQ-017 sae_int  output  1  internal sense-amp-enable strobe.
REQ-018 oob_err  output  1  sticky out-of-range access flag.

Function
REQ-019 An access SHALL be accepted on each rising clk edge with rst_n=1 and en=1; en=0 means no array access.
REQ-020 Write (en=1, we=1): granule g (bits g*MASK_GRAN+MASK_GRAN-1 .. g*MASK_GRAN) SHALL be updated from din only when wmask[g]=1; other granules unchanged.
REQ-021 Write SHALL NOT change dout or dout_valid; dout holds its last value.
REQ-022 Read (en=1, we=0): array data at addr SHALL be sampled at the accepting edge and appear on dout exactly READ_LATENCY edges later, with dout_valid=1 for that one cycle.
REQ-023 Read pipeline SHALL be fully pipelined: reads on consecutive cycles yield dout_valid on consecutive cycles, in order.
REQ-024 A write to an address accepted after a read of that address SHALL NOT change the in-flight read data (read returns old data).
REQ-025 Between read results dout SHALL hold the most recent read data; dout_valid=0.
REQ-026 sae_int SHALL be 1 for exactly the cycle after each accepted read edge, 0 otherwise; back-to-back reads keep it high continuously.
REQ-027 Access with addr >= RAM_DEPTH: write ignored; read returns all-zeros with normal latency and dout_valid; oob_err set to 1 on that edge.
REQ-028 oob_err SHALL remain 1 until reset.
REQ-029 The read pipeline SHALL advance every cycle regardless of en.
REQ-030 Array contents SHALL initialise to zero at simulation start only; no reset of the array.

Reset
REQ-031 rst_n=0 SHALL immediately, asynchronously, force dout=0, dout_valid=0, sae_int=0, oob_err=0 and clear all read-pipeline valid stages.
REQ-032 Reads in flight when reset asserts SHALL be discarded; no dout_valid for them after release.
REQ-033 Reset SHALL NOT modify array contents; data written before reset SHALL read back after release.
REQ-034 First access SHALL be accepted on the first rising edge with rst_n=1.

Verification
REQ-035 Defaults, write addr 0x123 din 0xA5 wmask 1, then read 0x123 -> dout=0xA5, dout_valid high exactly 1 cycle after read edge, sae_int high the same cycle.
REQ-036 DATA_WIDTH=32 MASK_GRAN=8: write 0xFFFFFFFF, then write 0x12345678 wmask 4'b0101, read -> 0xFF34FF78.
REQ-037 READ_LATENCY=3: reads of addrs 0,1,2 on consecutive edges (contents 0x11,0x22,0x33) -> dout 0x11,0x22,0x33 on edges 3,4,5 with dout_valid continuous; read addr 5 then write addr 5 next cycle -> old value returned.
REQ-038 RAM_DEPTH=3000: write 0xFF to addr 3000, then read addr 3000 -> dout=0x00 with dout_valid, oob_err=1 and sticky; a following legal read leaves oob_err=1.
REQ-039 READ_LATENCY=2: assert rst_n=0 mid-cycle one cycle after a read -> outputs 0 immediately, no dout_valid after release; earlier-written data still reads back correctly.
REQ-040 Write followed by idle cycles (en=0) -> dout keeps prior read value, dout_valid and sae_int stay 0.

Source files
------------

// File: rtl/sram22_param_model.sv
// Behavioural single-port SRAM model with per-granule write masks, a
// configurable read pipeline, sense-amp strobe and sticky out-of-range flag.
module sram22_param_model #(
   parameter int DATA_WIDTH   = 8,
   parameter int ADDR_WIDTH   = 12,
   parameter int RAM_DEPTH    = 1 << ADDR_WIDTH,
   parameter int MASK_GRAN    = 8,
   parameter int WMASK_WIDTH  = (MASK_GRAN > 0) ? DATA_WIDTH / MASK_GRAN : 1,
   parameter int READ_LATENCY = 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   en,
   input  logic                   we,
   input  logic [WMASK_WIDTH-1:0] wmask,
   input  logic [ADDR_WIDTH-1:0]  addr,
   input  logic [DATA_WIDTH-1:0]  din,
   output logic [DATA_WIDTH-1:0]  dout,
   output logic                   dout_valid,
   output logic                   sae_int,
   output logic                   oob_err
);

   localparam int IDX_W = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;

   if (DATA_WIDTH < 1 || ADDR_WIDTH < 1) begin : g_bad_width
      $error("sram22_param_model: DATA_WIDTH and ADDR_WIDTH must be at least 1");
   end
   if (RAM_DEPTH < 1 || longint'(RAM_DEPTH) > (longint'(1) << ADDR_WIDTH)) begin : g_bad_depth
      $error("sram22_param_model: RAM_DEPTH must be in 1..2**ADDR_WIDTH");
   end
   if (MASK_GRAN < 1 || (DATA_WIDTH % MASK_GRAN) != 0) begin : g_bad_gran
      $error("sram22_param_model: DATA_WIDTH must be a multiple of MASK_GRAN");
   end
   if (MASK_GRAN >= 1 && WMASK_WIDTH != DATA_WIDTH / MASK_GRAN) begin : g_bad_wmask
      $error("sram22_param_model: WMASK_WIDTH must equal DATA_WIDTH/MASK_GRAN");
   end
   if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
      $error("sram22_param_model: READ_LATENCY must be in 1..4");
   end

   logic [DATA_WIDTH-1:0] mem [RAM_DEPTH] = '{default: '0};
   logic [DATA_WIDTH-1:0] pipe_data [READ_LATENCY];
   logic [READ_LATENCY-1:0] pipe_valid;
   logic                  in_range;
   logic                  rd_accept;
   logic                  wr_accept;
   logic [IDX_W-1:0]      idx;
   logic [DATA_WIDTH-1:0] rd_sample;

   assign in_range  = {1'b0, addr} < (ADDR_WIDTH + 1)'(RAM_DEPTH);
   assign rd_accept = en & ~we;
   assign wr_accept = en & we;
   assign idx       = addr[IDX_W-1:0];
   assign rd_sample = in_range ? mem[idx] : '0;

   // The array is deliberately untouched by reset; only accesses while out of reset land.
   always_ff @(posedge clk or negedge rst_n) begin
      if (rst_n) begin
         if (wr_accept && in_range) begin
            for (int g = 0; g < WMASK_WIDTH; g++) begin
               if (wmask[g]) begin
                  mem[idx][g*MASK_GRAN +: MASK_GRAN] <= din[g*MASK_GRAN +: MASK_GRAN];
               end
            end
         end
      end
   end

   // Each stage only reloads data when a valid result arrives, so the last stage holds the latest read.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pipe_valid <= '0;
         for (int i = 0; i < READ_LATENCY; i++) begin
            pipe_data[i] <= '0;
         end
         oob_err <= 1'b0;
      end else begin
         pipe_valid[0] <= rd_accept;
         if (rd_accept) begin
            pipe_data[0] <= rd_sample;
         end
         for (int i = 1; i < READ_LATENCY; i++) begin
            pipe_valid[i] <= pipe_valid[i-1];
            if (pipe_valid[i-1]) begin
               pipe_data[i] <= pipe_data[i-1];
            end
         end
         if (en && !in_range) begin
            oob_err <= 1'b1;
         end
      end
   end

   assign dout       = pipe_data[READ_LATENCY-1];
   assign dout_valid = pipe_valid[READ_LATENCY-1];
   assign sae_int    = pipe_valid[0];

endmodule

// File: tb/tb_sram22_param_model.sv
// Scoreboard bench: two SRAM instances (8-bit latency 1, 32-bit masked latency 3 with
// 3000 words); directed vectors push hand-computed read results, a monitor checks them.
module tb_sram22_param_model;

   localparam int AW      = 12;
   localparam int LAT_B   = 3;
   localparam int DEPTH_B = 3000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;

   logic        en_a = 1'b0, we_a = 1'b0;
   logic [0:0]  wmask_a = '0;
   logic [AW-1:0] addr_a = '0;
   logic [7:0]  din_a = '0;
   logic [7:0]  dout_a;
   logic        dout_valid_a, sae_int_a, oob_err_a;

   logic        en_b = 1'b0, we_b = 1'b0;
   logic [3:0]  wmask_b = '0;
   logic [AW-1:0] addr_b = '0;
   logic [31:0] din_b = '0;
   logic [31:0] dout_b;
   logic        dout_valid_b, sae_int_b, oob_err_b;

   typedef struct {
      logic [31:0] data;
      longint      due;
   } exp_t;

   exp_t        q [2][$];
   logic [31:0] last [2];
   logic        oob_exp_b = 1'b0;
   longint      cyc = 0;
   int          total = 0;
   int          bad = 0;

   always #5 clk = ~clk;

   sram22_param_model u_a (
      .clk(clk), .rst_n(rst_n), .en(en_a), .we(we_a), .wmask(wmask_a),
      .addr(addr_a), .din(din_a), .dout(dout_a), .dout_valid(dout_valid_a),
      .sae_int(sae_int_a), .oob_err(oob_err_a)
   );

   sram22_param_model #(
      .DATA_WIDTH(32), .ADDR_WIDTH(AW), .RAM_DEPTH(DEPTH_B),
      .MASK_GRAN(8), .READ_LATENCY(LAT_B)
   ) u_b (
      .clk(clk), .rst_n(rst_n), .en(en_b), .we(we_b), .wmask(wmask_b),
      .addr(addr_b), .din(din_b), .dout(dout_b), .dout_valid(dout_valid_b),
      .sae_int(sae_int_b), .oob_err(oob_err_b)
   );

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   task automatic apply_stimulus(input int sel, input logic e, input logic w, input logic [AW-1:0] a,
                                 input logic [31:0] d, input logic [3:0] m, input logic [31:0] exp_rd);
      exp_t ent;
      @(negedge clk);
      en_a = 1'b0;
      en_b = 1'b0;
      if (sel == 0) begin
         en_a = e; we_a = w; addr_a = a; din_a = d[7:0]; wmask_a = m[0:0];
      end else begin
         en_b = e; we_b = w; addr_b = a; din_b = d; wmask_b = m;
      end
      if (e && !w) begin
         ent.data = exp_rd;
         ent.due  = cyc + ((sel == 0) ? 1 : LAT_B);
         q[sel].push_back(ent);
      end
   endtask

   task automatic wr(input int sel, input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] m);
      apply_stimulus(sel, 1'b1, 1'b1, a, d, m, 32'h0);
   endtask

   task automatic rd(input int sel, input logic [AW-1:0] a, input logic [31:0] exp_rd);
      apply_stimulus(sel, 1'b1, 1'b0, a, 32'h0, 4'h0, exp_rd);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         apply_stimulus(0, 1'b0, 1'b0, '0, 32'h0, 4'h0, 32'h0);
      end
   endtask

   task automatic monitor_one(input int sel, input logic v, input logic [31:0] d, input logic s,
                              input logic s_exp, input logic o, input logic o_exp);
      exp_t  ent;
      string tag;
      tag = (sel == 0) ? "a" : "b";
      check_output({tag, "_sae_int"}, {31'h0, s}, {31'h0, s_exp});
      check_output({tag, "_oob_err"}, {31'h0, o}, {31'h0, o_exp});
      if (v) begin
         if (q[sel].size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL %s_unexpected_valid: got dout_valid=1 expected 0 at cycle %0d", tag, cyc);
         end else begin
            ent = q[sel].pop_front();
            check_output({tag, "_dout"}, d, ent.data);
            check_output({tag, "_latency"}, 32'(cyc), 32'(ent.due));
            last[sel] = ent.data;
         end
      end else begin
         check_output({tag, "_dout_hold"}, d, last[sel]);
         if (q[sel].size() != 0 && q[sel][0].due <= cyc) begin
            ent = q[sel].pop_front();
            total++;
            bad++;
            $display("[TB] FAIL %s_missing_valid: got dout_valid=0 expected 1 (data %0h) at cycle %0d",
                     tag, ent.data, cyc);
         end
      end
   endtask

   always begin : monitor
      logic sae_exp_a, sae_exp_b;
      @(posedge clk);
      cyc++;
      sae_exp_a = rst_n & en_a & ~we_a;
      sae_exp_b = rst_n & en_b & ~we_b;
      if (!rst_n) begin
         oob_exp_b = 1'b0;
      end else if (en_b && addr_b >= 12'd3000) begin
         oob_exp_b = 1'b1;
      end
      #1;
      if (!rst_n) begin
         last[0] = '0;
         last[1] = '0;
      end else begin
         monitor_one(0, dout_valid_a, {24'h0, dout_a}, sae_int_a, sae_exp_a, oob_err_a, 1'b0);
         monitor_one(1, dout_valid_b, dout_b, sae_int_b, sae_exp_b, oob_err_b, oob_exp_b);
      end
   end

   initial begin : watchdog
      #200000;
      $display("[TB] FAIL watchdog: got no completion expected finish before time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : stimulus
      last[0] = '0;
      last[1] = '0;
      #3;
      check_output("rst_dout_a", {24'h0, dout_a}, 32'h0);
      check_output("rst_valid_a", {31'h0, dout_valid_a}, 32'h0);
      check_output("rst_dout_b", dout_b, 32'h0);
      check_output("rst_valid_b", {31'h0, dout_valid_b}, 32'h0);
      check_output("rst_sae_b", {31'h0, sae_int_b}, 32'h0);
      check_output("rst_oob_b", {31'h0, oob_err_b}, 32'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // 8-bit, latency 1: basic write/read, masked-off write, back-to-back reads, idle hold
      wr(0, 12'h123, 32'hA5, 4'h1);
      rd(0, 12'h123, 32'hA5);
      wr(0, 12'h124, 32'h3C, 4'h0);
      rd(0, 12'h124, 32'h00);
      wr(0, 12'hFFF, 32'h5A, 4'h1);
      rd(0, 12'h123, 32'hA5);
      rd(0, 12'hFFF, 32'h5A);
      rd(0, 12'h123, 32'hA5);
      wr(0, 12'h010, 32'h77, 4'h1);
      idle(3);
      rd(0, 12'h010, 32'h77);

      // 32-bit, latency 3: partial mask, pipelined reads, read-before-write, out of range
      wr(1, 12'h010, 32'hFFFFFFFF, 4'hF);
      wr(1, 12'h010, 32'h12345678, 4'b0101);
      rd(1, 12'h010, 32'hFF34FF78);
      wr(1, 12'h000, 32'h11, 4'hF);
      wr(1, 12'h001, 32'h22, 4'hF);
      wr(1, 12'h002, 32'h33, 4'hF);
      rd(1, 12'h000, 32'h11);
      rd(1, 12'h001, 32'h22);
      rd(1, 12'h002, 32'h33);
      wr(1, 12'h005, 32'hAB, 4'hF);
      rd(1, 12'h005, 32'hAB);
      wr(1, 12'h005, 32'hCD, 4'hF);
      rd(1, 12'h005, 32'hCD);
      wr(1, 12'd3000, 32'hFF, 4'hF);
      rd(1, 12'd3000, 32'h0);
      rd(1, 12'h000, 32'h11);
      idle(4);

      // Reset with a read in flight: it must vanish, array contents must survive
      rd(1, 12'h010, 32'hFF34FF78);
      idle(1);
      #2;
      rst_n = 1'b0;
      q[0].delete();
      q[1].delete();
      #1;
      check_output("async_rst_dout_b", dout_b, 32'h0);
      check_output("async_rst_valid_b", {31'h0, dout_valid_b}, 32'h0);
      check_output("async_rst_sae_b", {31'h0, sae_int_b}, 32'h0);
      check_output("async_rst_oob_b", {31'h0, oob_err_b}, 32'h0);
      check_output("async_rst_dout_a", {24'h0, dout_a}, 32'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      idle(5);
      rd(1, 12'h010, 32'hFF34FF78);
      rd(1, 12'h002, 32'h33);
      rd(0, 12'h123, 32'hA5);
      idle(6);

      check_output("drain_a", q[0].size(), 32'h0);
      check_output("drain_b", q[1].size(), 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
